// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer and the core datapath/memories.
// Latency: none, wires only.
// Backpressure: imem_ready/dmem_ready stall the sequencer in FETCH/MEM respectively.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_wr_en;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_wr_en;
  logic             pc_wr_en;
  logic             pc_src;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  // Sequencer side
  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_wr_en, dmem_req, dmem_we, reg_wr_en, pc_wr_en, pc_src,
    output state, illegal, instret
  );

  // Datapath / memory side
  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_wr_en, dmem_req, dmem_we, reg_wr_en, pc_wr_en, pc_src,
    input  state, illegal, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// RV32I multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB phase enables, memory requests, PC strobes.
// Latency: BRANCH 3, ALU/JUMP/STORE 4, LOAD 5 cycles with zero wait states; each wait state adds 1.
// Backpressure: holds in FETCH until imem_ready, in MEM until dmem_ready. Optional SEQ_MEM_TIMEOUT_EN halts after 255 wait cycles.
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL
  } cls_t;

  state_t           state_q;
  cls_t             cls_q;
  cls_t             dec_cls;
  logic             illegal_q;
  logic [CNT_W-1:0] instret_q;

  logic imem_req, ir_wr_en, dmem_req, dmem_we, reg_wr_en, pc_wr_en, pc_src;

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: classify = C_ALU;
      7'b0000011:                                     classify = C_LOAD;
      7'b0100011:                                     classify = C_STORE;
      7'b1100011:                                     classify = C_BRANCH;
      7'b1101111, 7'b1100111:                         classify = C_JUMP;
      default:                                        classify = C_ILLEGAL;
    endcase
  endfunction

  // Opcode class as seen by the DECODE phase
  always_comb dec_cls = classify(bus.opcode);

  // Phase enables: pure decode of state, class and the owning ready; all zero while in reset
  always_comb begin
    imem_req  = 1'b0;
    ir_wr_en  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_wr_en = 1'b0;
    pc_wr_en  = 1'b0;
    pc_src    = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_wr_en = bus.imem_ready;
        end
        S_EXEC: begin
          if (cls_q == C_BRANCH) begin
            pc_wr_en = 1'b1;
            pc_src   = bus.branch_taken;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == C_STORE);
          pc_wr_en = bus.dmem_ready && (cls_q == C_STORE);
        end
        S_WB: begin
          reg_wr_en = 1'b1;
          pc_wr_en  = 1'b1;
          pc_src    = (cls_q == C_JUMP);
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       waiting;
  logic       timeout;

  // A wait cycle is one where the phase owner's ready is low
  always_comb begin
    waiting = ((state_q == S_FETCH) && !bus.imem_ready) || ((state_q == S_MEM) && !bus.dmem_ready);
    timeout = waiting && (wait_cnt_q == 8'hFF);
  end

  // Wait counter: runs only while stalled, so it is zero on every entry to FETCH or MEM
  always_ff @(posedge clk) begin
    if (!rst_n || !waiting) wait_cnt_q <= 8'd0;
    else                    wait_cnt_q <= wait_cnt_q + 8'd1;
  end
`endif

  // Phase FSM with class latch, sticky illegal flag and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= C_ALU;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (pc_wr_en) instret_q <= instret_q + CNT_W'(1);
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ready) state_q <= S_DECODE;
`ifdef SEQ_MEM_TIMEOUT_EN
          else if (timeout) begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
`endif
        end
        S_DECODE: begin
          cls_q <= dec_cls;
          if (dec_cls == C_ILLEGAL) begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (cls_q)
            C_BRANCH:        state_q <= S_FETCH;
            C_LOAD, C_STORE: state_q <= S_MEM;
            default:         state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) state_q <= (cls_q == C_STORE) ? S_FETCH : S_WB;
`ifdef SEQ_MEM_TIMEOUT_EN
          else if (timeout) begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
          end
`endif
        end
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Drive the bundle
  always_comb begin
    bus.imem_req  = imem_req;
    bus.ir_wr_en  = ir_wr_en;
    bus.dmem_req  = dmem_req;
    bus.dmem_we   = dmem_we;
    bus.reg_wr_en = reg_wr_en;
    bus.pc_wr_en  = pc_wr_en;
    bus.pc_src    = pc_src;
    bus.state     = state_q;
    bus.illegal   = illegal_q;
    bus.instret   = instret_q;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I core. It sequences one shared instruction/data memory path, the register file and the PC register through the phases FETCH, DECODE, EXEC, MEM and WB.
- It handshakes with instruction and data memory so that either can insert wait states.
- It sits beside the combinational decoder, which still produces the ALU/mux selects. This block produces only the phase enables, memory requests and PC write strobes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- opcode  in  7  opcode field of the instruction register; valid from DECODE onward.
- branch_taken  in  1  branch comparator result; sampled in EXEC.
- imem_ready  in  1  instruction memory has data; completes a fetch.
- dmem_ready  in  1  data memory has completed the access.
- imem_req  out  1  instruction fetch request.
- ir_wr_en  out  1  load the instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- reg_wr_en  out  1  register file write.
- pc_wr_en  out  1  PC register update.
- pc_src  out  1  PC select: 0 = PC+4, 1 = ALU target.
- state  out  3  current state, for debug and the bench.
- illegal  out  1  sticky illegal-opcode flag.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-low (rst_n).
- While rst_n = 0, on every clock edge:
  - state loads FETCH; illegal and instret load 0; the class register clears.
  - All enable outputs are forced to 0 combinationally.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- All enables are combinational from state, ready inputs and the class register. No output is registered except state, illegal and instret.
- Class register: written in DECODE from opcode. Classes:
  - ALU: 0110011, 0010011, 0110111, 0010111.
  - LOAD: 0000011.
  - STORE: 0100011.
  - BRANCH: 1100011.
  - JUMP: 1101111, 1100111.
  - Any other opcode is ILLEGAL.
- FETCH:
  - imem_req = 1.
  - If imem_ready: ir_wr_en = 1, go to DECODE. Otherwise stay.
  - A ready in the same cycle as the request gives a 1-cycle fetch.
- DECODE:
  - No enables.
  - ILLEGAL: go to HALT and set illegal.
  - Otherwise latch the class and go to EXEC.
- EXEC:
  - BRANCH: pc_wr_en = 1, pc_src = branch_taken, go to FETCH; the instruction retires.
  - LOAD and STORE: go to MEM.
  - ALU and JUMP: go to WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE only.
  - Hold until dmem_ready.
  - On ready, STORE: pc_wr_en = 1, pc_src = 0, go to FETCH; the instruction retires.
  - On ready, LOAD: go to WB.
- WB:
  - reg_wr_en = 1, pc_wr_en = 1, pc_src = 1 for JUMP else 0.
  - Go to FETCH; the instruction retires.
- HALT:
  - All enables 0; imem_req = 0.
  - illegal stays 1.
  - Exit only through reset.
- Retire: instret increments by 1 in every cycle where pc_wr_en = 1. It wraps modulo 2^CNT_W.
- Latencies with zero wait states:
  - BRANCH: 3 cycles.
  - ALU, JUMP, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait-state cycle adds 1.
- Ready inputs are ignored outside the state that owns them: imem_ready outside FETCH, dmem_ready outside MEM.
- Reset during MEM or FETCH: the request is abandoned. It drops combinationally in the reset cycle, and no pc_wr_en or reg_wr_en occurs.
- Invalid state codes 6 and 7 recover to FETCH on the next edge.

Optional Feature:
- Macro: SEQ_MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle the ready input is low.
  - When it reaches 255, the block goes to HALT and sets illegal.
  - The counter resets to 0.
- Undefined:
  - No counter exists.
  - Waits are unbounded, and HALT is reached only through an illegal opcode.

Test Plan:
- ADD (0110011), both readies tied 1:
  - States run FETCH, DECODE, EXEC, WB, FETCH.
  - reg_wr_en = 1 and pc_wr_en = 1 only in WB, pc_src = 0.
  - instret goes from 0 to 1.
- LW (0000011), dmem_ready low for 3 MEM cycles:
  - dmem_req is high for 4 cycles with dmem_we = 0.
  - reg_wr_en pulses once in WB.
  - Instruction takes 8 cycles in total.
- SW (0100011), then BEQ (1100011) with branch_taken = 1:
  - SW: dmem_we = 1 in MEM and reg_wr_en is never 1.
  - BEQ: pc_src = 1 in EXEC and completes in 3 cycles.
  - instret = 2.
- JAL (1101111):
  - pc_src = 1 together with reg_wr_en = 1 in WB.
- Opcode 0000000:
  - DECODE goes to HALT, illegal = 1.
  - imem_req stays 0 for 20 or more cycles.
  - rst_n low for 1 cycle returns to FETCH with illegal = 0.
- rst_n asserted mid-MEM during a store with dmem_ready = 0:
  - dmem_req drops in the reset cycle and no pc_wr_en occurs.
  - state = FETCH and instret = 0 after reset.
